dither_stage: RTL and testbench

- Pixel-stream stage directly upstream of the grayscale stage. It reduces 8-bit-per-channel RGB from the frame source to the 4-bit-per-channel RGB the grayscale and colour-scramble stages consume.
- Uses 1-D horizontal error diffusion: each channel's residual error is carried into the next pixel of the same line.
- Tracks column and row position, clears error at line boundaries, and presents a one-deep valid/ready registered output.

---
 rtl/dither_stage.sv | 205 ++++++++++++++++++++
 tb/tb_dither_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_stage.sv
// dither_stage: 8->4 bit RGB reduction with 1-D horizontal error diffusion.
// Define DITHER_NOISE_EN to seed line-start errors from an 8-bit LFSR.
module dither_stage #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int IN_W     = 8,
   parameter int OUT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SW,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [IN_W-1:0]  R_in,
   input  logic [IN_W-1:0]  G_in,
   input  logic [IN_W-1:0]  B_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic             out_eol,
   output logic [OUT_W-1:0] R_dither,
   output logic [OUT_W-1:0] G_dither,
   output logic [OUT_W-1:0] B_dither
);

   localparam int EW = IN_W - OUT_W;
   localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

   // Result packs {quantised value, residual}; saturation drops the residual.
   function automatic logic [IN_W-1:0] quant(
      input logic [IN_W-1:0] px,
      input logic [EW-1:0]   e,
      input logic            dith
   );
      logic [IN_W:0] s;
      s = {1'b0, px} + {{(IN_W + 1 - EW){1'b0}}, e};
      if (!dith)
         quant = {px[IN_W-1:EW], {EW{1'b0}}};
      else if (s[IN_W])
         quant = {{OUT_W{1'b1}}, {EW{1'b0}}};
      else
         quant = s[IN_W-1:0];
   endfunction

   logic             accept;
   logic             xfer;
   logic             line_end;
   logic             tag_first;

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;

   logic [EW-1:0]    err_r_q, err_r_d;
   logic [EW-1:0]    err_g_q, err_g_d;
   logic [EW-1:0]    err_b_q, err_b_d;
   logic [EW-1:0]    e_r, e_g, e_b;
   logic [EW-1:0]    seed_r, seed_g, seed_b;
   logic [IN_W-1:0]  q_r, q_g, q_b;

   logic             valid_q, valid_d;
   logic             sof_q, sof_d;
   logic             eol_q, eol_d;
   logic [OUT_W-1:0] r_q, r_d;
   logic [OUT_W-1:0] g_q, g_d;
   logic [OUT_W-1:0] b_q, b_d;

   assign in_ready  = !valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign xfer      = valid_q && out_ready;
   assign line_end  = !in_sof && (col_q == COL_LAST);
   assign tag_first = in_sof || ((col_q == '0) && (row_q == '0));

   assign out_valid = valid_q;
   assign out_sof   = sof_q;
   assign out_eol   = eol_q;
   assign R_dither  = r_q;
   assign G_dither  = g_q;
   assign B_dither  = b_q;

`ifdef DITHER_NOISE_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic       lfsr_fb;

   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_comb begin
      lfsr_d = lfsr_q;
      if (accept && (in_sof || line_end))
         lfsr_d = {lfsr_q[6:0], lfsr_fb};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr_q <= 8'hA5;
      else
         lfsr_q <= lfsr_d;
   end

   assign seed_r = lfsr_q[3:0];
   assign seed_g = lfsr_q[7:4];
   assign seed_b = lfsr_q[5:2];
`else
   assign seed_r = '0;
   assign seed_g = '0;
   assign seed_b = '0;
`endif

   // A start-of-frame pixel never inherits error from the previous stream.
   assign e_r = in_sof ? '0 : err_r_q;
   assign e_g = in_sof ? '0 : err_g_q;
   assign e_b = in_sof ? '0 : err_b_q;

   assign q_r = quant(R_in, e_r, SW);
   assign q_g = quant(G_in, e_g, SW);
   assign q_b = quant(B_in, e_b, SW);

   always_comb begin
      err_r_d = err_r_q;
      err_g_d = err_g_q;
      err_b_d = err_b_q;
      if (accept) begin
         if (!SW) begin
            err_r_d = '0;
            err_g_d = '0;
            err_b_d = '0;
         end else if (line_end) begin
            err_r_d = seed_r;
            err_g_d = seed_g;
            err_b_d = seed_b;
         end else begin
            err_r_d = q_r[EW-1:0];
            err_g_d = q_g[EW-1:0];
            err_b_d = q_b[EW-1:0];
         end
      end
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (in_sof) begin
            col_d = CW'(1);
            row_d = '0;
         end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      if (accept) begin
         valid_d = 1'b1;
         sof_d   = tag_first;
         eol_d   = line_end;
         r_d     = q_r[IN_W-1:EW];
         g_d     = q_g[IN_W-1:EW];
         b_d     = q_b[IN_W-1:EW];
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         err_r_q <= '0;
         err_g_q <= '0;
         err_b_q <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         err_r_q <= err_r_d;
         err_g_q <= err_g_d;
         err_b_q <= err_b_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

endmodule

// File: tb/tb_dither_stage.sv
// tb_dither_stage: randomized and directed checks of dither_stage against
// an arithmetic reference model with a small line (H=4, V=3).
module tb_dither_stage;

   localparam int H = 4;
   localparam int V = 3;

   logic       clk;
   logic       rst;
   logic       SW;
   logic       in_valid;
   logic       in_ready;
   logic       in_sof;
   logic [7:0] R_in, G_in, B_in;
   logic       out_valid;
   logic       out_ready;
   logic       out_sof;
   logic       out_eol;
   logic [3:0] R_dither, G_dither, B_dither;

   dither_stage #(.H_ACTIVE(H), .V_ACTIVE(V), .IN_W(8), .OUT_W(4)) dut (
      .clk(clk), .rst(rst), .SW(SW),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .R_in(R_in), .G_in(G_in), .B_in(B_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol),
      .R_dither(R_dither), .G_dither(G_dither), .B_dither(B_dither)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // reference model state
   int          m_col, m_row;
   int          m_err [3];
   bit          exp_valid;
   logic [14:0] exp_pk;

   function automatic logic [14:0] obs();
      return {out_sof, out_eol, R_dither, G_dither, B_dither};
   endfunction

   task automatic model_reset();
      m_col = 0;
      m_row = 0;
      for (int i = 0; i < 3; i++) m_err[i] = 0;
      exp_valid = 0;
      exp_pk = '0;
   endtask

   task automatic model_accept(input bit sw, input bit sof,
                               input int r, input int g, input int b);
      int px [3];
      int o [3];
      int tc, tr, e, s, ne;
      px[0] = r; px[1] = g; px[2] = b;
      tc = sof ? 0 : m_col;
      tr = sof ? 0 : m_row;
      for (int ch = 0; ch < 3; ch++) begin
         e = sof ? 0 : m_err[ch];
         s = px[ch] + e;
         if (!sw) begin
            o[ch] = px[ch] / 16;
            ne = 0;
         end else if (s > 255) begin
            o[ch] = 15;
            ne = 0;
         end else begin
            o[ch] = s / 16;
            ne = s % 16;
         end
         m_err[ch] = (tc == H - 1) ? 0 : ne;
      end
      if (sof) begin
         m_col = 1;
         m_row = 0;
      end else if (m_col == H - 1) begin
         m_col = 0;
         m_row = (m_row + 1) % V;
      end else begin
         m_col = m_col + 1;
      end
      exp_valid = 1;
      exp_pk = {1'(tc == 0 && tr == 0), 1'(tc == H - 1),
                4'(o[0]), 4'(o[1]), 4'(o[2])};
   endtask

   task automatic cycle(input bit v, input bit sof, input bit sw,
                        input bit ordy, input int r, input int g,
                        input int b);
      bit acc, xf;
      in_valid  = v;
      in_sof    = sof;
      SW        = sw;
      out_ready = ordy;
      R_in = 8'(r);
      G_in = 8'(g);
      B_in = 8'(b);
      acc = v && (!exp_valid || ordy);
      xf  = exp_valid && ordy;
      @(posedge clk);
      #1;
      if (acc) model_accept(sw, sof, r, g, b);
      else if (xf) exp_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1; SW = 1; in_valid = 0; in_sof = 0; out_ready = 1;
      R_in = 0; G_in = 0; B_in = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      n_chk++;
      if ({in_ready, out_valid, obs()} !== {1'b1, 1'b0, 15'h0})
         $display("FAIL reset_init: got %h want %h",
                  {in_ready, out_valid, obs()}, {1'b1, 1'b0, 15'h0});
      else n_pass++;
      cycle(1, 1, 1, 0, 8'h37, 8'h8A, 8'hF3);
      cycle(1, 0, 1, 0, 8'h11, 8'h22, 8'h33);
      in_valid = 0;
      #2;
      rst = 1;
      #1;
      model_reset();
      n_chk++;
      if ({in_ready, out_valid, obs()} !== {1'b1, 1'b0, 15'h0})
         $display("FAIL reset_mid: got %h want %h",
                  {in_ready, out_valid, obs()}, {1'b1, 1'b0, 15'h0});
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 0;
      cycle(1, 1, 1, 1, 8'h08, 8'h08, 8'h08);
      n_chk++;
      if ({out_valid, out_sof} !== 2'b11)
         $display("FAIL reset_first_sof: got %b want 11",
                  {out_valid, out_sof});
      else n_pass++;
   endtask

   task automatic test_pattern();
      int pat [4] = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         cycle(1, i == 0, 1, 1, 8'h08, 8'h08, 8'h08);
         n_chk++;
         if ({out_valid, R_dither, G_dither, B_dither} !==
             {1'b1, 4'(pat[i]), 4'(pat[i]), 4'(pat[i])})
            $display("FAIL pattern08[%0d]: got %h%h%h want %0d",
                     i, R_dither, G_dither, B_dither, pat[i]);
         else n_pass++;
         n_chk++;
         if ({out_valid, obs()} !== {exp_valid, exp_pk})
            $display("FAIL pattern08_model[%0d]: got %h want %h",
                     i, {out_valid, obs()}, {exp_valid, exp_pk});
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      cycle(1, 1, 1, 1, 8'h08, 8'h08, 8'h08);
      cycle(1, 0, 1, 1, 8'hFF, 8'h08, 8'h08);
      n_chk++;
      if ({R_dither, G_dither} !== {4'd15, 4'd1})
         $display("FAIL saturate: got R=%0d G=%0d want R=15 G=1",
                  R_dither, G_dither);
      else n_pass++;
      cycle(1, 0, 1, 1, 8'h00, 8'h08, 8'h08);
      n_chk++;
      if (R_dither !== 4'd0)
         $display("FAIL sat_no_carry: got %0d want 0", R_dither);
      else n_pass++;
      n_chk++;
      if ({out_valid, obs()} !== {exp_valid, exp_pk})
         $display("FAIL sat_model: got %h want %h",
                  {out_valid, obs()}, {exp_valid, exp_pk});
      else n_pass++;
   endtask

   task automatic test_truncation();
      cycle(1, 0, 1, 1, 8'h07, 8'h0B, 8'h0E);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 0, 1, 8'h9C, 8'h3F, 8'hF0);
         n_chk++;
         if ({R_dither, G_dither, B_dither} !== {4'd9, 4'd3, 4'd15})
            $display("FAIL truncate[%0d]: got %0d,%0d,%0d want 9,3,15",
                     i, R_dither, G_dither, B_dither);
         else n_pass++;
      end
   endtask

   task automatic test_eol_sof();
      int pat [4] = '{0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         cycle(1, i == 0, 1, 1, 8'h08, 8'h08, 8'h08);
         n_chk++;
         if ({out_eol, R_dither, B_dither} !==
             {1'((i % 4) == 3), 4'(pat[i % 4]), 4'(pat[i % 4])})
            $display("FAIL eol_line[%0d]: got eol=%b R=%0d want eol=%b R=%0d",
                     i, out_eol, R_dither, (i % 4) == 3, pat[i % 4]);
         else n_pass++;
      end
      cycle(1, 0, 1, 1, 8'h08, 8'h08, 8'h08);
      cycle(1, 0, 1, 1, 8'h08, 8'h08, 8'h08);
      cycle(1, 1, 1, 1, 8'h08, 8'h08, 8'h08);
      n_chk++;
      if ({out_sof, out_eol, R_dither} !== {1'b1, 1'b0, 4'd0})
         $display("FAIL sof_resync: got sof=%b eol=%b R=%0d want 1,0,0",
                  out_sof, out_eol, R_dither);
      else n_pass++;
      cycle(1, 0, 1, 1, 8'h08, 8'h08, 8'h08);
      n_chk++;
      if ({out_sof, R_dither} !== {1'b0, 4'd1})
         $display("FAIL sof_next: got sof=%b R=%0d want 0,1",
                  out_sof, R_dither);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int r, g, b;
      logic [14:0] held;
      cycle(1, 0, 1, 1, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255));
      cycle(1, 0, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255));
      held = exp_pk;
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 1, 0, r, g, b);
         n_chk++;
         if ({in_ready, out_valid, obs()} !== {1'b0, 1'b1, held})
            $display("FAIL stall[%0d]: got %h want %h", i,
                     {in_ready, out_valid, obs()}, {1'b0, 1'b1, held});
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         cycle(i < 2, 0, 1, 1, r + i, g, b);
         n_chk++;
         if ({out_valid, obs()} !== {exp_valid, exp_pk})
            $display("FAIL release[%0d]: got %h want %h", i,
                     {out_valid, obs()}, {exp_valid, exp_pk});
         else n_pass++;
      end
   endtask

   task automatic test_random();
      bit sw = 1;
      int errs = 0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 9) == 0) sw = !sw;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, sw,
               $urandom_range(0, 9) < 7, $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255));
         n_chk++;
         if ({in_ready, out_valid, obs()} !==
             {1'(!exp_valid || out_ready), exp_valid, exp_pk}) begin
            if (errs < 10)
               $display("FAIL random[%0d]: got %h want %h", i,
                        {in_ready, out_valid, obs()},
                        {1'(!exp_valid || out_ready), exp_valid, exp_pk});
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_pattern();
      test_saturation();
      test_truncation();
      test_eol_sof();
      test_backpressure();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
